// File: rtl/pkt_rx_buffer.sv
// -----------------------------------------------------------------------------
// pkt_rx_buffer
//
// Receives one 14-bit packet word per cycle from the packet register stage,
// filters it by destination address, buffers accepted packets in a FIFO and
// presents them on a show-ahead valid/ready output. The upstream stage has no
// backpressure, so packets arriving while the FIFO is full are dropped and
// counted.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   packet_in   [13] reserved, [12] valid, [11:8] dest, [7:0] data
//   filter_en   1 = accept only NODE_ADDR / BCAST_ADDR, 0 = accept all valid
//   out_valid   head entry available (== !empty)
//   out_ready   consumer accepts head entry
//   out_dest    dest field of head entry (0 while empty)
//   out_data    data field of head entry (0 while empty)
//   fifo_count  occupancy 0..DEPTH
//   full        fifo_count == DEPTH
//   empty       fifo_count == 0
//   filt_cnt    saturating count of valid packets rejected by the filter
//   drop_cnt    saturating count of matching packets lost to a full FIFO
//
// Output handshake: an entry transfers on a rising edge where out_valid and
// out_ready are both 1. out_valid never depends on out_ready, and the head
// fields stay stable while out_valid is 1 and out_ready is 0.
// -----------------------------------------------------------------------------
module pkt_rx_buffer #(
  parameter int          DEPTH      = 8,
  parameter logic [3:0]  NODE_ADDR  = 4'h3,
  parameter logic [3:0]  BCAST_ADDR = 4'hF,
  parameter int          CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [13:0]              packet_in,
  input  logic                     filter_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_dest,
  output logic [7:0]               out_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         filt_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Storage and pointers. Pointers are AW bits so they wrap modulo DEPTH.
  logic [11:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CNT_W-1:0] r_filt_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  // Packet decode. Bit 13 is reserved and intentionally has no effect.
  logic       w_unused_rsvd;
  logic       w_pkt_valid;
  logic [3:0] w_pkt_dest;
  logic [7:0] w_pkt_data;
  assign w_unused_rsvd = packet_in[13];
  assign w_pkt_valid   = packet_in[12];
  assign w_pkt_dest    = packet_in[11:8];
  assign w_pkt_data    = packet_in[7:0];

  logic w_full;
  logic w_empty;
  logic w_match;
  logic w_pop;
  logic w_push;
  logic w_filt;
  logic w_drop;
  logic [11:0] w_head;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_match = !filter_en || (w_pkt_dest == NODE_ADDR) || (w_pkt_dest == BCAST_ADDR);
  assign w_pop   = !w_empty && out_ready;
  // A full FIFO still accepts a packet when the head leaves in the same cycle.
  assign w_push  = w_pkt_valid && w_match && (!w_full || w_pop);
  assign w_filt  = w_pkt_valid && !w_match;
  assign w_drop  = w_pkt_valid && w_match && w_full && !w_pop;
  assign w_head  = r_mem[r_rd_ptr];

  // Storage array holds data only; validity comes from r_count, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= {w_pkt_dest, w_pkt_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_filt_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_filt && (r_filt_cnt != '1)) begin
        r_filt_cnt <= r_filt_cnt + CNT_W'(1);
      end
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid  = !w_empty;
  assign out_dest   = w_empty ? 4'h0 : w_head[11:8];
  assign out_data   = w_empty ? 8'h00 : w_head[7:0];
  assign fifo_count = r_count;
  assign full       = w_full;
  assign empty      = w_empty;
  assign filt_cnt   = r_filt_cnt;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_pkt_rx_buffer.sv
module tb_pkt_rx_buffer;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main DUT (default parameters)
  logic [13:0] packet_in = '0;
  logic        filter_en = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [3:0]  out_dest;
  logic [7:0]  out_data;
  logic [3:0]  fifo_count;
  logic        full;
  logic        empty;
  logic [15:0] filt_cnt;
  logic [15:0] drop_cnt;

  pkt_rx_buffer u_dut (
    .clk(clk), .rst(rst), .packet_in(packet_in), .filter_en(filter_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_dest(out_dest),
    .out_data(out_data), .fifo_count(fifo_count), .full(full), .empty(empty),
    .filt_cnt(filt_cnt), .drop_cnt(drop_cnt)
  );

  // Narrow-counter instance for saturation
  logic [13:0] s_packet_in = '0;
  logic        s_out_valid;
  logic [3:0]  s_out_dest;
  logic [7:0]  s_out_data;
  logic [3:0]  s_fifo_count;
  logic        s_full;
  logic        s_empty;
  logic [3:0]  s_filt_cnt;
  logic [3:0]  s_drop_cnt;

  pkt_rx_buffer #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .packet_in(s_packet_in), .filter_en(1'b1),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_dest(s_out_dest),
    .out_data(s_out_data), .fifo_count(s_fifo_count), .full(s_full), .empty(s_empty),
    .filt_cnt(s_filt_cnt), .drop_cnt(s_drop_cnt)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [11:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every transfer on the output must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got %0h expected none at %0t", {out_dest, out_data}, $time);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({out_dest, out_data} !== e) begin
          n_fail++;
          $display("FAIL out_entry: got %0h expected %0h at %0t", {out_dest, out_data}, e, $time);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: apply one cycle of stimulus; acc says whether the bench expects
  // the packet to enter the FIFO. Bit 13 is randomised to show it is ignored.
  // Returns at 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic cyc(input logic v, input logic [3:0] d, input logic [7:0] dat,
                     input logic acc, input logic fe, input logic rdy);
    packet_in = {1'($urandom_range(0, 1)), v, d, dat};
    filter_en = fe;
    out_ready = rdy;
    if (acc) exp_q.push_back({d, dat});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 8'h00, 1'b0, 1'b1, rdy);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_out_dest", 32'(out_dest), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_filt", 32'(filt_cnt), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    rst = 1'b0;

    // 1: single matching packet visible the cycle after sampling
    cyc(1'b1, 4'h3, 8'hA5, 1'b1, 1'b1, 1'b0);
    chk("t1_out_valid", 32'(out_valid), 1);
    chk("t1_out_dest", 32'(out_dest), 3);
    chk("t1_out_data", 32'(out_data), 8'hA5);
    chk("t1_count", 32'(fifo_count), 1);
    cyc(1'b0, 4'h3, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("t1_hold_data", 32'(out_data), 8'hA5);

    // 2: filter on, dests 2/15/3 with consumer ready
    cyc(1'b1, 4'h2, 8'h21, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 4'hF, 8'h22, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 4'h3, 8'h23, 1'b1, 1'b1, 1'b1);
    idle(3, 1'b1);
    chk("t2_filt", 32'(filt_cnt), 1);
    chk("t2_count", 32'(fifo_count), 0);
    chk("t2_empty", 32'(empty), 1);

    // 3: filter off, 10 packets without draining -> 2 drops
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 4'h5, 8'(i), (i < 8), 1'b0, 1'b0);
      if (i == 6) chk("t3_not_full7", 32'(full), 0);
      if (i == 7) chk("t3_full8", 32'(full), 1);
    end
    chk("t3_count", 32'(fifo_count), 8);
    chk("t3_drop", 32'(drop_cnt), 2);
    chk("t3_filt", 32'(filt_cnt), 1);
    idle(7, 1'b1);
    chk("t3_empty_after7", 32'(empty), 0);
    idle(1, 1'b1);
    chk("t3_empty_after8", 32'(empty), 1);
    chk("t3_out_data0", 32'(out_data), 0);

    // 4: full FIFO, pop and push in the same cycle
    for (int i = 0; i < 8; i++) cyc(1'b1, 4'h3, 8'h10 + 8'(i), 1'b1, 1'b1, 1'b0);
    chk("t4_full", 32'(full), 1);
    cyc(1'b1, 4'hF, 8'hEE, 1'b1, 1'b1, 1'b1);
    chk("t4_count", 32'(fifo_count), 8);
    chk("t4_drop", 32'(drop_cnt), 2);
    idle(8, 1'b1);
    chk("t4_empty", 32'(empty), 1);

    // filter_en applies only to its own cycle; invalid words do nothing
    cyc(1'b1, 4'h7, 8'h71, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 4'h7, 8'h72, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 4'h7, 8'h73, 1'b0, 1'b1, 1'b0);
    chk("t4b_filt", 32'(filt_cnt), 2);
    chk("t4b_count", 32'(fifo_count), 1);
    idle(2, 1'b1);

    // 5: reset with 5 entries buffered and a valid packet presented
    for (int i = 0; i < 5; i++) cyc(1'b1, 4'h3, 8'h50 + 8'(i), 1'b1, 1'b1, 1'b0);
    chk("t5_count5", 32'(fifo_count), 5);
    rst = 1'b1;
    exp_q.delete();
    cyc(1'b1, 4'h3, 8'h99, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    chk("t5_count", 32'(fifo_count), 0);
    chk("t5_out_valid", 32'(out_valid), 0);
    chk("t5_out_data", 32'(out_data), 0);
    chk("t5_filt", 32'(filt_cnt), 0);
    chk("t5_drop", 32'(drop_cnt), 0);
    idle(1, 1'b1);
    chk("t5_no_ghost", 32'(out_valid), 0);

    // 6: saturation on the 4-bit counter instance
    for (int i = 0; i < 20; i++) begin
      s_packet_in = {2'b01, 4'h1, 8'(i)};
      @(posedge clk);
      #1;
      if (i == 13) chk("t6_filt14", 32'(s_filt_cnt), 4'hE);
    end
    s_packet_in = '0;
    chk("t6_filt_sat", 32'(s_filt_cnt), 4'hF);
    chk("t6_sat_empty", 32'(s_empty), 1);

    idle(2, 1'b1);
    chk("leftover_expected", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
